// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: initiator side of the single-cycle STB/ACK register bus.
// Accepts one command at a time from a local requester, runs it on the bus,
// and returns read data (or a timeout error) on a valid/ready response port.
// All outputs are registered.
// Optional feature macro: BUS_MASTER_CTRL_RETRY_EN. When defined, the first
// timeout re-issues the strobe once after a single low cycle, and only the
// second timeout reports an error.
module bus_master_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iCMD_VLD,
   output logic              oCMD_RDY,
   input  logic [ADDR_W-1:0] iCMD_ADR,
   input  logic              iCMD_WE,
   input  logic [DATA_W-1:0] iCMD_WDAT,
   output logic              oRSP_VLD,
   input  logic              iRSP_RDY,
   output logic [DATA_W-1:0] oRSP_DAT,
   output logic              oRSP_ERR,
   output logic [ADDR_W-1:0] oADR,
   output logic [DATA_W-1:0] oDAT,
   output logic              oSTB,
   output logic              oWE,
   input  logic [DATA_W-1:0] iDAT,
   input  logic              iACK
);

`ifdef BUS_MASTER_CTRL_RETRY_EN
   typedef enum logic [1:0] {IDLE, BUS, RESP, RETRY} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
`endif

   // Last counter value before the strobe is abandoned; counter never wraps.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     state;
   logic [7:0] toutCnt;
`ifdef BUS_MASTER_CTRL_RETRY_EN
   logic       retried;
`endif

   // Command/bus/response sequencer with all outputs registered.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state    <= IDLE;
         toutCnt  <= '0;
`ifdef BUS_MASTER_CTRL_RETRY_EN
         retried  <= 1'b0;
`endif
         oCMD_RDY <= 1'b1;
         oRSP_VLD <= 1'b0;
         oRSP_DAT <= '0;
         oRSP_ERR <= 1'b0;
         oADR     <= '0;
         oDAT     <= '0;
         oSTB     <= 1'b0;
         oWE      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
`ifdef BUS_MASTER_CTRL_RETRY_EN
               retried <= 1'b0;
`endif
               if (iCMD_VLD) begin
                  oADR     <= iCMD_ADR;
                  oWE      <= iCMD_WE;
                  oDAT     <= iCMD_WE ? iCMD_WDAT : '0;
                  oSTB     <= 1'b1;
                  oCMD_RDY <= 1'b0;
                  toutCnt  <= '0;
                  state    <= BUS;
               end
            end

            BUS: begin
               if (iACK) begin
                  // ACK takes priority over a coincident timeout.
                  oSTB     <= 1'b0;
                  oWE      <= 1'b0;
                  oRSP_DAT <= oWE ? '0 : iDAT;
                  oRSP_ERR <= 1'b0;
                  oRSP_VLD <= 1'b1;
                  state    <= RESP;
               end else if (toutCnt == TIMEOUT_LAST) begin
`ifdef BUS_MASTER_CTRL_RETRY_EN
                  if (!retried) begin
                     // First timeout: drop the strobe for one cycle, keep the
                     // address/data/WE so the retry repeats the same access.
                     oSTB  <= 1'b0;
                     state <= RETRY;
                  end else begin
                     oSTB     <= 1'b0;
                     oWE      <= 1'b0;
                     oRSP_DAT <= '0;
                     oRSP_ERR <= 1'b1;
                     oRSP_VLD <= 1'b1;
                     state    <= RESP;
                  end
`else
                  oSTB     <= 1'b0;
                  oWE      <= 1'b0;
                  oRSP_DAT <= '0;
                  oRSP_ERR <= 1'b1;
                  oRSP_VLD <= 1'b1;
                  state    <= RESP;
`endif
               end else begin
                  toutCnt <= toutCnt + 8'd1;
               end
            end

`ifdef BUS_MASTER_CTRL_RETRY_EN
            RETRY: begin
               oSTB    <= 1'b1;
               toutCnt <= '0;
               retried <= 1'b1;
               state   <= BUS;
            end
`endif

            RESP: begin
               if (iRSP_RDY) begin
                  oRSP_VLD <= 1'b0;
                  oCMD_RDY <= 1'b1;
                  state    <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Testbench for bus_master_ctrl: directed transactions, a transaction-level
// timeline model of the expected outputs checked every cycle, plus literal
// spot checks of key results.
module tb_bus_master_ctrl;

   localparam int T = 16;
`ifdef BUS_MASTER_CTRL_RETRY_EN
   localparam int TO_STB = 2 * T;
`else
   localparam int TO_STB = T;
`endif

   logic        iCLK, iRST;
   logic        iCMD_VLD, oCMD_RDY;
   logic [31:0] iCMD_ADR;
   logic        iCMD_WE;
   logic [31:0] iCMD_WDAT;
   logic        oRSP_VLD, iRSP_RDY;
   logic [31:0] oRSP_DAT;
   logic        oRSP_ERR;
   logic [31:0] oADR, oDAT;
   logic        oSTB, oWE;
   logic [31:0] iDAT;
   logic        iACK;

   bus_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iCMD_VLD(iCMD_VLD), .oCMD_RDY(oCMD_RDY), .iCMD_ADR(iCMD_ADR),
      .iCMD_WE(iCMD_WE), .iCMD_WDAT(iCMD_WDAT),
      .oRSP_VLD(oRSP_VLD), .iRSP_RDY(iRSP_RDY), .oRSP_DAT(oRSP_DAT),
      .oRSP_ERR(oRSP_ERR),
      .oADR(oADR), .oDAT(oDAT), .oSTB(oSTB), .oWE(oWE),
      .iDAT(iDAT), .iACK(iACK)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   typedef struct packed {
      logic        rdy, stb, we, vld, err;
      logic [31:0] adr, dat, rdat;
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nErrors = 0;
   int   stbTotal = 0;

   // Model state: values the DUT must be holding between transactions.
   logic [31:0] mAdr, mDat, mRspDat;
   logic        mRspErr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic rdy, input logic stb, input logic we, input logic vld);
      exp_t e;
      e.rdy = rdy; e.stb = stb; e.we = we; e.vld = vld;
      e.err = mRspErr; e.adr = mAdr; e.dat = mDat; e.rdat = mRspDat;
      expQ.push_back(e);
   endtask

   task automatic modelReset();
      mAdr = '0; mDat = '0; mRspDat = '0; mRspErr = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iCLK); #2;
         iCMD_VLD = 1'b0; iACK = 1'($urandom); iRSP_RDY = 1'($urandom);
         iDAT = $urandom;
         push(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // One command from presentation to response acceptance. ackAt counts STB
   // cycles from 1 (across a retry if any); 0 means the slave never ACKs.
   task automatic runTxn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input int ackAt, input logic [31:0] rdat, input int rdyDelay);
      int  stbN;
      int  passes;
      bit  done;
      bit  hit;
      // presentation cycle (IDLE); a stray ACK here must be ignored
      @(posedge iCLK); #2;
      iCMD_VLD = 1'b1; iCMD_ADR = adr; iCMD_WE = we; iCMD_WDAT = wdat;
      iACK = 1'b1; iDAT = $urandom; iRSP_RDY = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b0);
      mAdr = adr;
      mDat = we ? wdat : 32'h0;
`ifdef BUS_MASTER_CTRL_RETRY_EN
      passes = 2;
`else
      passes = 1;
`endif
      stbN = 0;
      done = 1'b0;
      for (int p = 0; p < passes && !done; p++) begin
         if (p > 0) begin
            @(posedge iCLK); #2;
            iCMD_VLD = 1'b0; iACK = 1'b0; iDAT = $urandom;
            push(1'b0, 1'b0, we, 1'b0);
         end
         for (int k = 1; k <= T && !done; k++) begin
            @(posedge iCLK); #2;
            stbN++;
            hit = (stbN == ackAt);
            iCMD_VLD = 1'b0; iACK = hit; iDAT = hit ? rdat : $urandom;
            push(1'b0, 1'b1, we, 1'b0);
            if (hit) done = 1'b1;
         end
      end
      mRspDat = (done && !we) ? rdat : 32'h0;
      mRspErr = !done;
      // response phase: a pending junk command and stray ACKs must be ignored
      for (int r = 0; r <= rdyDelay; r++) begin
         @(posedge iCLK); #2;
         iCMD_VLD = 1'b1; iCMD_ADR = $urandom; iCMD_WE = 1'($urandom);
         iCMD_WDAT = $urandom; iACK = 1'b1; iDAT = $urandom;
         iRSP_RDY = (r == rdyDelay);
         push(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // Bounded run time.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      iRST = 1'b1; iCMD_VLD = 1'b0; iCMD_ADR = '0; iCMD_WE = 1'b0; iCMD_WDAT = '0;
      iRSP_RDY = 1'b0; iDAT = '0; iACK = 1'b0;
      modelReset();

      // Per-cycle comparison against the model timeline.
      fork
         forever begin
            @(negedge iCLK);
            if (oSTB) stbTotal++;
            if (expQ.size() > 0) begin
               exp_t e;
               e = expQ.pop_front();
               chk("cmdRdy", 32'(oCMD_RDY), 32'(e.rdy));
               chk("stb",    32'(oSTB),     32'(e.stb));
               chk("we",     32'(oWE),      32'(e.we));
               chk("adr",    oADR,          e.adr);
               chk("dat",    oDAT,          e.dat);
               chk("rspVld", 32'(oRSP_VLD), 32'(e.vld));
               chk("rspDat", oRSP_DAT,      e.rdat);
               chk("rspErr", 32'(oRSP_ERR), 32'(e.err));
            end
         end
      join_none

      repeat (2) @(posedge iCLK);
      #1;
      chk("rst_cmdRdy", 32'(oCMD_RDY), 32'd1);
      chk("rst_stb",    32'(oSTB),     32'd0);
      chk("rst_rspVld", 32'(oRSP_VLD), 32'd0);
      chk("rst_adr",    oADR,          32'h0);
      #1 iRST = 1'b0;
      idleCycles(2);

      // Read, ACK on 2nd STB cycle.
      s0 = stbTotal;
      runTxn(32'h0200_0100, 1'b0, 32'h0, 2, 32'h1234_5678, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("rd_stbCycles", 32'(stbTotal - s0), 32'd2);
      chk("rd_data",      oRSP_DAT,           32'h1234_5678);
      chk("rd_err",       32'(oRSP_ERR),      32'd0);
      chk("rd_adrHeld",   oADR,               32'h0200_0100);

      // Write, ACK on 1st STB cycle; read data on the bus must not leak.
      s0 = stbTotal;
      runTxn(32'h0200_0104, 1'b1, 32'hA5A5_0001, 1, 32'hDEAD_BEEF, 1);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("wr_stbCycles", 32'(stbTotal - s0), 32'd1);
      chk("wr_rspDat",    oRSP_DAT,           32'h0);
      chk("wr_datHeld",   oDAT,               32'hA5A5_0001);

      // Read, never ACKed -> timeout error.
      s0 = stbTotal;
      runTxn(32'h0200_0200, 1'b0, 32'h0, 0, 32'h0, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("to_stbCycles", 32'(stbTotal - s0), 32'(TO_STB));
      chk("to_err",       32'(oRSP_ERR),      32'd1);
      chk("to_rspDat",    oRSP_DAT,           32'h0);

      // Response held 5 cycles with iRSP_RDY low; back-to-back next command.
      runTxn(32'h0200_0300, 1'b0, 32'h0, 3, 32'hCAFE_F00D, 5);
      runTxn(32'h0200_0304, 1'b0, 32'h0, 15, 32'h0BAD_CAFE, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("ack15_data", oRSP_DAT, 32'h0BAD_CAFE);

      // ACK on the timeout edge: ACK wins.
      s0 = stbTotal;
      runTxn(32'h0200_0308, 1'b0, 32'h0, 16, 32'h5A5A_A5A5, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("ackTo_err",       32'(oRSP_ERR),      32'd0);
      chk("ackTo_data",      oRSP_DAT,           32'h5A5A_A5A5);
      chk("ackTo_stbCycles", 32'(stbTotal - s0), 32'd16);

      // Write that times out.
      runTxn(32'h0200_030C, 1'b1, 32'h1111_2222, 0, 32'h0, 2);
      idleCycles(1);

`ifdef BUS_MASTER_CTRL_RETRY_EN
      // ACK during the retry pass gives a normal response.
      runTxn(32'h0200_0310, 1'b0, 32'h0, T + 3, 32'h7777_8888, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("retry_data", oRSP_DAT, 32'h7777_8888);
      chk("retry_err",  32'(oRSP_ERR), 32'd0);
`endif

      // Reset during the 3rd STB cycle.
      @(posedge iCLK); #2;
      iCMD_VLD = 1'b1; iCMD_ADR = 32'h0200_0400; iCMD_WE = 1'b0; iACK = 1'b0;
      iRSP_RDY = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b0);
      mAdr = 32'h0200_0400; mDat = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge iCLK); #2;
         iCMD_VLD = 1'b0; iACK = 1'b0;
         push(1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(posedge iCLK); #2;
      chk("rstBus_stbBefore", 32'(oSTB), 32'd1);
      iRST = 1'b1;
      #1;
      chk("rstBus_stb",    32'(oSTB),     32'd0);
      chk("rstBus_cmdRdy", 32'(oCMD_RDY), 32'd1);
      chk("rstBus_rspVld", 32'(oRSP_VLD), 32'd0);
      modelReset();
      @(posedge iCLK); #2;
      iRST = 1'b0;
      runTxn(32'h0200_0500, 1'b0, 32'h0, 2, 32'h2468_ACE0, 0);
      idleCycles(1);
      @(negedge iCLK); #1;
      chk("postRst_data", oRSP_DAT, 32'h2468_ACE0);

      // Reset while a response is pending.
      @(posedge iCLK); #2;
      iCMD_VLD = 1'b1; iCMD_ADR = 32'h0200_0600; iCMD_WE = 1'b0; iACK = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b0);
      mAdr = 32'h0200_0600; mDat = 32'h0;
      @(posedge iCLK); #2;
      iCMD_VLD = 1'b0; iACK = 1'b1; iDAT = 32'h1357_9BDF;
      push(1'b0, 1'b1, 1'b0, 1'b0);
      mRspDat = 32'h1357_9BDF; mRspErr = 1'b0;
      @(posedge iCLK); #2;
      iACK = 1'b0; iRSP_RDY = 1'b0;
      chk("rstRsp_vldBefore", 32'(oRSP_VLD), 32'd1);
      iRST = 1'b1;
      #1;
      chk("rstRsp_vld",    32'(oRSP_VLD), 32'd0);
      chk("rstRsp_cmdRdy", 32'(oCMD_RDY), 32'd1);
      chk("rstRsp_dat",    oRSP_DAT,      32'h0);
      modelReset();
      @(posedge iCLK); #2;
      iRST = 1'b0;
      idleCycles(3);
      repeat (2) @(negedge iCLK);
      if (expQ.size() != 0) begin
         nChecks++;
         nErrors++;
         $display("FAIL drain: got %0d pending expectations expected 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
